// File: rtl/snoop_pkg.sv
// Shared encodings for the MSI snooping cache: bus message codes, line states,
// message field positions and controller FSM states.
package snoop_pkg;

  localparam int NLINES  = 4;
  localparam int MSG_HI  = 8;
  localparam int MSG_LO  = 7;
  localparam int ADDR_HI = 6;
  localparam int ADDR_LO = 4;
  localparam int DATA_HI = 3;
  localparam int DATA_LO = 0;

  typedef enum logic [1:0] {
    MSG_RM  = 2'd0,
    MSG_WB  = 2'd1,
    MSG_WM  = 2'd2,
    MSG_INV = 2'd3
  } msg_e;

  typedef enum logic [1:0] {
    ST_I = 2'd0,
    ST_S = 2'd1,
    ST_M = 2'd2
  } msi_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_MISS_REQ,
    S_INV_REQ,
    S_WAIT_MEM
  } fsm_e;

  function automatic logic [8:0] mk_msg(input msg_e m, input logic [2:0] a, input logic [3:0] d);
    return {m, a, d};
  endfunction

endpackage

// File: rtl/snoop_wb_fifo.sv
// Small FIFO holding snoop-forced write-backs; head is visible combinationally.
// Push while full is ignored unless a pop happens in the same cycle.
module snoop_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 7
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [W-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= bump(wr_q);
      end
      if (do_pop) rd_q <= bump(rd_q);
      if (do_push != do_pop) cnt_q <= do_push ? cnt_q + CW'(1) : cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/snoop_cache_ctrl.sv
// MSI snooping cache controller, 4 direct-mapped lines; hits complete next cycle, misses go over the bus.
// cpu_ready drops outside IDLE or while snoop write-backs are queued; bus_req holds until granted.
module snoop_cache_ctrl
  import snoop_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int WB_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_valid,
  input  logic       cpu_write,
  input  logic [2:0] cpu_addr,
  input  logic [3:0] cpu_wdata,
  output logic       cpu_ready,
  output logic       cpu_done,
  output logic [3:0] cpu_rdata,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [8:0] bus_out,
  output logic       bus_out_valid,
  input  logic [8:0] snoop_in,
  input  logic       snoop_valid,
  input  logic [8:0] mem_data,
  output logic       wb_overflow
);
  localparam int CW = $clog2(MEM_LAT + 2);

  fsm_e          state_q, state_d;
  msi_e          st_q [NLINES];
  msi_e          st_d [NLINES];
  msi_e          snp_st [NLINES];
  logic          tag_q [NLINES];
  logic          tag_d [NLINES];
  logic [3:0]    dat_q [NLINES];
  logic [3:0]    dat_d [NLINES];
  logic          req_wr_q, req_wr_d, wb_buf_q, wb_buf_d;
  logic [2:0]    req_addr_q, req_addr_d;
  logic [3:0]    req_wdata_q, req_wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d, bus_req_q, bus_req_d, bus_vld_q, bus_vld_d, ovf_q, ovf_d;
  logic [8:0]    bus_out_q, bus_out_d;

  msg_e       s_msg;
  logic [2:0] s_addr;
  logic [1:0] s_idx, c_idx, r_idx;
  logic       snp_push, fifo_pop, fifo_empty, fifo_full, grant, victim_dirty, inv_lost;
  logic [6:0] snp_push_dat, fifo_head;
  logic [8:0] miss_msg;
  logic       unused_ok;

  assign s_msg     = msg_e'(snoop_in[MSG_HI:MSG_LO]);
  assign s_addr    = snoop_in[ADDR_HI:ADDR_LO];
  assign s_idx     = s_addr[1:0];
  assign c_idx     = cpu_addr[1:0];
  assign r_idx     = req_addr_q[1:0];
  assign unused_ok = ^{mem_data[8:4], snoop_in[DATA_HI:DATA_LO]};

  // Snoop view of the line array; the FSM below decides and writes on top of it.
  always_comb begin
    for (int i = 0; i < NLINES; i++) snp_st[i] = st_q[i];
    snp_push     = 1'b0;
    snp_push_dat = {s_addr, dat_q[s_idx]};
    if (snoop_valid && st_q[s_idx] != ST_I && tag_q[s_idx] == s_addr[2]) begin
      case (st_q[s_idx])
        ST_M: begin
          if (s_msg == MSG_RM) begin
            snp_push      = 1'b1;
            snp_st[s_idx] = ST_S;
          end else if (s_msg == MSG_WM) begin
            snp_push      = 1'b1;
            snp_st[s_idx] = ST_I;
          end
        end
        ST_S: if (s_msg == MSG_WM || s_msg == MSG_INV) snp_st[s_idx] = ST_I;
        default: ;
      endcase
    end
  end

  snoop_wb_fifo #(.DEPTH(WB_DEPTH), .W(7)) u_wb_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (snp_push),
    .push_dat (snp_push_dat),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .head     (fifo_head)
  );

  assign cpu_ready    = (state_q == S_IDLE) && fifo_empty;
  assign grant        = bus_req_q && bus_gnt;
  assign victim_dirty = (snp_st[r_idx] == ST_M);
  assign inv_lost     = (snp_st[r_idx] == ST_I);
  assign miss_msg     = mk_msg(req_wr_q ? MSG_WM : MSG_RM, req_addr_q, 4'h0);

  always_comb begin
    state_d     = state_q;
    for (int i = 0; i < NLINES; i++) begin
      st_d[i]  = snp_st[i];
      tag_d[i] = tag_q[i];
      dat_d[i] = dat_q[i];
    end
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    wb_buf_d    = wb_buf_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    bus_out_d   = '0;
    bus_vld_d   = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          wb_buf_d = 1'b1;
          state_d  = S_WB_REQ;
        end else if (cpu_valid) begin
          req_wr_d    = cpu_write;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          if (snp_st[c_idx] != ST_I && tag_q[c_idx] == cpu_addr[2]) begin
            if (!cpu_write) begin
              done_d  = 1'b1;
              rdata_d = dat_q[c_idx];
            end else if (snp_st[c_idx] == ST_M) begin
              dat_d[c_idx] = cpu_wdata;
              done_d       = 1'b1;
            end else begin
              state_d = S_INV_REQ;
            end
          end else if (snp_st[c_idx] == ST_M) begin
            wb_buf_d = 1'b0;
            state_d  = S_WB_REQ;
          end else begin
            state_d = S_MISS_REQ;
          end
        end
      end
      S_WB_REQ: begin
        if (wb_buf_q) begin
          if (grant) begin
            bus_out_d = mk_msg(MSG_WB, fifo_head[6:4], fifo_head[3:0]);
            bus_vld_d = 1'b1;
            fifo_pop  = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (!victim_dirty) begin
          // A snoop already cleaned the victim, so go straight to the miss.
          if (grant) begin
            bus_out_d = miss_msg;
            bus_vld_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT_MEM;
          end else begin
            state_d = S_MISS_REQ;
          end
        end else if (grant) begin
          bus_out_d   = mk_msg(MSG_WB, {tag_q[r_idx], r_idx}, dat_q[r_idx]);
          bus_vld_d   = 1'b1;
          st_d[r_idx] = ST_I;
          state_d     = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (grant) begin
          bus_out_d = miss_msg;
          bus_vld_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT_MEM;
        end
      end
      S_INV_REQ: begin
        if (inv_lost) begin
          if (grant) begin
            bus_out_d = miss_msg;
            bus_vld_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT_MEM;
          end else begin
            state_d = S_MISS_REQ;
          end
        end else if (grant) begin
          bus_out_d    = mk_msg(MSG_INV, req_addr_q, 4'h0);
          bus_vld_d    = 1'b1;
          st_d[r_idx]  = ST_M;
          dat_d[r_idx] = req_wdata_q;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_WAIT_MEM: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          tag_d[r_idx] = req_addr_q[2];
          if (req_wr_q) begin
            st_d[r_idx]  = ST_M;
            dat_d[r_idx] = req_wdata_q;
          end else begin
            st_d[r_idx]  = ST_S;
            dat_d[r_idx] = mem_data[DATA_HI:DATA_LO];
            rdata_d      = mem_data[DATA_HI:DATA_LO];
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    bus_req_d = (state_d == S_WB_REQ || state_d == S_MISS_REQ || state_d == S_INV_REQ) && !bus_vld_d;
    ovf_d     = ovf_q | (snp_push & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NLINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      wb_buf_q    <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_out_q   <= '0;
      bus_vld_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NLINES; i++) begin
        st_q[i]  <= st_d[i];
        tag_q[i] <= tag_d[i];
        dat_q[i] <= dat_d[i];
      end
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      wb_buf_q    <= wb_buf_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_out_q   <= bus_out_d;
      bus_vld_q   <= bus_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cpu_done      = done_q;
  assign cpu_rdata     = rdata_q;
  assign bus_req       = bus_req_q;
  assign bus_out       = bus_out_q;
  assign bus_out_valid = bus_vld_q;
  assign wb_overflow   = ovf_q;

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Directed bench for snoop_cache_ctrl: expected bus messages and completions are queued
// by the stimulus and matched by an independent monitor.
module tb_snoop_cache_ctrl;
  localparam int         MEM_LAT = 1;
  localparam logic [8:0] JUNK    = 9'h1F5;

  logic       clock, reset_n;
  logic       cpu_valid, cpu_write, cpu_ready, cpu_done;
  logic [2:0] cpu_addr;
  logic [3:0] cpu_wdata, cpu_rdata;
  logic       bus_req, bus_gnt, bus_out_valid, snoop_valid, wb_overflow;
  logic [8:0] bus_out, snoop_in, mem_data;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic       gnt_en;
  logic [8:0] exp_bus[$];
  logic [4:0] exp_done[$];
  logic [3:0] mem_arr [8];

  snoop_cache_ctrl #(.MEM_LAT(MEM_LAT), .WB_DEPTH(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cpu_valid     (cpu_valid),
    .cpu_write     (cpu_write),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ready     (cpu_ready),
    .cpu_done      (cpu_done),
    .cpu_rdata     (cpu_rdata),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_out       (bus_out),
    .bus_out_valid (bus_out_valid),
    .snoop_in      (snoop_in),
    .snoop_valid   (snoop_valid),
    .mem_data      (mem_data),
    .wb_overflow   (wb_overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  function automatic logic [8:0] m(input logic [1:0] c, input logic [2:0] a, input logic [3:0] d);
    return {c, a, d};
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // One-cycle grant whenever enabled and requested.
  initial begin
    bus_gnt = 1'b0;
    forever begin
      @(negedge clock);
      bus_gnt = gnt_en && bus_req && !bus_gnt;
    end
  end

  // Memory: answers readMiss/writeMiss MEM_LAT cycles after the message, absorbs writeBacks.
  initial begin
    int         pend;
    logic [2:0] pend_addr;
    pend      = 0;
    pend_addr = '0;
    mem_data  = JUNK;
    forever begin
      @(negedge clock);
      mem_data = JUNK;
      if (pend > 0) begin
        pend--;
        if (pend == 0) mem_data = {5'b0, mem_arr[pend_addr]};
      end
      if (reset_n && bus_out_valid) begin
        if (bus_out[8:7] == 2'd0 || bus_out[8:7] == 2'd2) begin
          pend      = MEM_LAT;
          pend_addr = bus_out[6:4];
        end else if (bus_out[8:7] == 2'd1) begin
          mem_arr[bus_out[6:4]] = bus_out[3:0];
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [8:0] eb;
    logic [4:0] ed;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (bus_out_valid) begin
          if (exp_bus.size() == 0) begin
            chk_cnt++;
            $display("FAIL bus_unexpected: got message 0x%0h, expected none", bus_out);
          end else begin
            eb = exp_bus.pop_front();
            check("bus_msg", 32'(bus_out), 32'(eb));
          end
        end
        if (cpu_done) begin
          if (exp_done.size() == 0) begin
            chk_cnt++;
            $display("FAIL done_unexpected: got cpu_done with rdata 0x%0h, expected none", cpu_rdata);
          end else begin
            ed = exp_done.pop_front();
            if (ed[4]) check("load_rdata", 32'(cpu_rdata), 32'(ed[3:0]));
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cpu_req(input logic wr, input logic [2:0] a, input logic [3:0] d);
    int n;
    n         = 0;
    cpu_valid = 1'b1;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    while (!cpu_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      chk_cnt++;
      $display("FAIL accept_timeout: cpu_ready low for %0d cycles, expected acceptance", n);
    end
    @(negedge clock);
    cpu_valid = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] c, input logic [2:0] a);
    snoop_in    = m(c, a, 4'h0);
    snoop_valid = 1'b1;
    @(negedge clock);
    snoop_valid = 1'b0;
    snoop_in    = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_bus.size() != 0 || exp_done.size() != 0) && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(exp_bus.size() + exp_done.size()), 32'd0);
    cycles(1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_arr[i] = 4'h0;
    mem_arr[5]  = 4'hA;
    mem_arr[6]  = 4'hC;
    reset_n     = 1'b0;
    gnt_en      = 1'b1;
    cpu_valid   = 1'b0;
    cpu_write   = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    snoop_in    = '0;
    snoop_valid = 1'b0;
    cycles(3);
    check("rst_outputs", 32'({cpu_done, cpu_rdata, bus_req, bus_out, bus_out_valid, wb_overflow}), 32'd0);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    reset_n = 1'b1;
    cycles(1);

    // Cold load miss, then hit.
    exp_bus.push_back(m(0, 5, 0)); exp_done.push_back({1'b1, 4'hA});
    cpu_req(0, 5, 0); wait_drain("drain_load5_miss");
    exp_done.push_back({1'b1, 4'hA});
    cpu_req(0, 5, 0); check("hit_latency", 32'(cpu_done), 32'd1); wait_drain("drain_load5_hit");

    // Store to S line upgrades via invalidate; later load hits.
    exp_bus.push_back(m(3, 5, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 5, 4'h3); wait_drain("drain_upgrade");
    exp_done.push_back({1'b1, 4'h3});
    cpu_req(0, 5, 0); check("hit_latency_m", 32'(cpu_done), 32'd1); wait_drain("drain_load5_m");

    // Dirty victims: writeBack then miss message, each on its own grant.
    exp_bus.push_back(m(1, 5, 3)); exp_bus.push_back(m(2, 1, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 1, 4'h7); wait_drain("drain_store1");
    exp_bus.push_back(m(1, 1, 7)); exp_bus.push_back(m(0, 5, 0)); exp_done.push_back({1'b1, 4'h3});
    cpu_req(0, 5, 0); wait_drain("drain_victim_load5");

    // Snoop readMiss on an M line queues a write-back ahead of the CPU.
    exp_bus.push_back(m(2, 2, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 2, 4'h9); wait_drain("drain_store2");
    snoop(0, 2);
    check("ready_blocked", 32'(cpu_ready), 32'd0);
    exp_bus.push_back(m(1, 2, 9)); exp_done.push_back({1'b1, 4'h9});
    cpu_req(0, 2, 0); wait_drain("drain_snoop_wb");
    exp_bus.push_back(m(3, 2, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 2, 4'h4); wait_drain("drain_line2_shared");

    // Invalidate lost to a snoop before grant becomes a writeMiss.
    exp_bus.push_back(m(1, 2, 4)); exp_bus.push_back(m(0, 6, 0)); exp_done.push_back({1'b1, 4'hC});
    cpu_req(0, 6, 0); wait_drain("drain_load6");
    gnt_en = 1'b0;
    exp_bus.push_back(m(2, 6, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 6, 4'hE);
    cycles(3);
    check("inv_req_held", 32'(bus_req), 32'd1);
    snoop(3, 6);
    cycles(2);
    gnt_en = 1'b1;
    wait_drain("drain_inv_convert");
    exp_done.push_back({1'b1, 4'hE});
    cpu_req(0, 6, 0); wait_drain("drain_load6_m");

    // Buffer overflow with the bus withheld.
    exp_bus.push_back(m(2, 0, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 0, 4'h1); wait_drain("drain_store0");
    exp_bus.push_back(m(2, 3, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 3, 4'h2); wait_drain("drain_store3");
    exp_bus.push_back(m(3, 5, 0)); exp_done.push_back({1'b0, 4'h0});
    cpu_req(1, 5, 4'h6); wait_drain("drain_store5");
    gnt_en = 1'b0;
    snoop(2, 0);
    snoop(2, 3);
    check("ovf_full_ok", 32'(wb_overflow), 32'd0);
    snoop(2, 5);
    check("ovf_set", 32'(wb_overflow), 32'd1);
    exp_bus.push_back(m(1, 0, 1)); exp_bus.push_back(m(1, 3, 2));
    gnt_en = 1'b1;
    wait_drain("drain_wb_buffer");
    check("ovf_sticky", 32'(wb_overflow), 32'd1);

    // Reset while a miss is waiting for the bus.
    gnt_en = 1'b0;
    cpu_req(0, 1, 0);
    cycles(3);
    check("miss_req_held", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({cpu_done, cpu_rdata, bus_req, bus_out, bus_out_valid, wb_overflow}), 32'd0);
    check("rst_mid_ready", 32'(cpu_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    gnt_en  = 1'b1;
    cycles(1);
    exp_bus.push_back(m(0, 5, 0)); exp_done.push_back({1'b1, 4'h3});
    cpu_req(0, 5, 0); wait_drain("drain_post_reset");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
